// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot / thermometer decoder with an auto-scan index
// that steps up or down at a programmable rate, for LED banks and digit scanning.
module decoder_scan #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] in,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] d,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_THERMO    = 2'b01,
    MODE_SCAN_UP   = 2'b10,
    MODE_SCAN_DOWN = 2'b11
  } mode_e;

  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_MAX  = '1;
  localparam logic [SEL_W-1:0] IDX_ZERO = '0;
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);

  logic [OUT_W-1:0] d_q, d_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  mode_e            mode_q, mode_d;
  mode_e            mode_in;
  logic             mode_chg;

  assign mode_in = mode_e'(mode);

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Shifting the one-hot past the top bit yields 0, so 0 - 1 gives all ones at idx=max.
  function automatic logic [OUT_W-1:0] thermo(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] oh;
    oh = onehot(i);
    return (oh << 1) - OUT_ONE;
  endfunction

  always_comb begin
    d_d      = '0;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    mode_d   = mode_q;
    mode_chg = 1'b0;
    if (en) begin
      mode_d   = mode_in;
      mode_chg = (mode_in != mode_q);
      case (mode_in)
        MODE_DIRECT, MODE_THERMO: begin
          idx_d = in;
          cnt_d = '0;
        end
        default: begin
          // A mode change restarts the divider but keeps idx, so a scan
          // continues from the last directly selected value.
          if (load) begin
            idx_d = in;
            cnt_d = '0;
          end else if (mode_chg) begin
            cnt_d = '0;
          end else if (cnt_q == div) begin
            cnt_d = '0;
            if (mode_in == MODE_SCAN_UP) begin
              idx_d  = idx_q + IDX_ONE;
              wrap_d = (idx_q == IDX_MAX);
            end else begin
              idx_d  = idx_q - IDX_ONE;
              wrap_d = (idx_q == IDX_ZERO);
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
      d_d = (mode_in == MODE_THERMO) ? thermo(idx_d) : onehot(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      mode_q <= MODE_DIRECT;
    end else begin
      d_q    <= d_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
